// File: rtl/core_trace_mon.sv
// core_trace_mon: retire-trace monitor for an out-of-order core.
//   Tracks every ROB entry from alloc to retire. Each retire becomes a
//   {robid, pc, latency, nuke} record pushed into a trace FIFO. The block
//   also keeps sticky protocol error flags and a hang watchdog.
// Ports:
//   clk, reset_n                        clock, async active-low reset
//   alloc_valid/robid/pc                ROB allocation
//   res_valid/res_robid                 result writeback, NUM_RES ports
//   ret_valid/ret_robid/ret_nuke        retire, NUM_RET lanes (packed from lane 0)
//   cfg_timeout, hang_clr               watchdog threshold (0 = off) and clear
//   trace_valid/ready/data              trace record stream
//   hang, err_vec, drop_cnt, outstanding status
// Optional: define CORE_TRACE_MON_LATSTAT_EN to add lat_max / lat_max_robid.
module core_trace_mon #(
  parameter int ROB_IDW     = 5,
  parameter int NUM_RES     = 2,
  parameter int NUM_RET     = 2,
  parameter int TRACE_DEPTH = 16,
  parameter int TS_W        = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         alloc_valid,
  input  logic [ROB_IDW-1:0]           alloc_robid,
  input  logic [31:0]                  alloc_pc,
  input  logic [NUM_RES-1:0]           res_valid,
  input  logic [NUM_RES*ROB_IDW-1:0]   res_robid,
  input  logic [NUM_RET-1:0]           ret_valid,
  input  logic [NUM_RET*ROB_IDW-1:0]   ret_robid,
  input  logic                         ret_nuke,
  input  logic [TS_W-1:0]              cfg_timeout,
  input  logic                         hang_clr,
  output logic                         trace_valid,
  input  logic                         trace_ready,
  output logic [ROB_IDW+32+TS_W:0]     trace_data,
  output logic                         hang,
  output logic [2:0]                   err_vec,
  output logic [15:0]                  drop_cnt,
  output logic [ROB_IDW:0]             outstanding
`ifdef CORE_TRACE_MON_LATSTAT_EN
  ,
  output logic [TS_W-1:0]              lat_max,
  output logic [ROB_IDW-1:0]           lat_max_robid
`endif
);
  localparam int NENT = 1 << ROB_IDW;
  localparam int PW   = $clog2(TRACE_DEPTH);

  typedef struct packed {
    logic [ROB_IDW-1:0] robid;
    logic [31:0]        pc;
    logic [TS_W-1:0]    lat;
    logic               nuke;
  } rec_t;

  typedef enum logic [1:0] {WD_IDLE, WD_RUN, WD_HANG} wd_t;

  logic [NUM_RES-1:0][ROB_IDW-1:0] res_id;
  logic [NUM_RET-1:0][ROB_IDW-1:0] ret_id;
  assign res_id = res_robid;
  assign ret_id = ret_robid;

  logic [TS_W-1:0]             ts;
  logic [NENT-1:0]             tv, tr, tv_n, tr_n;
  logic [NENT-1:0][31:0]       tpc;
  logic [NENT-1:0][TS_W-1:0]   tts;
  rec_t [NUM_RET-1:0]          rec;
  logic [NUM_RET-1:0]          hi_oh, push;
  logic [NUM_RET-1:0][PW-1:0]  slot;
  logic [2:0]                  err_n;
  rec_t [TRACE_DEPTH-1:0]      mem;
  logic [PW:0]                 wp, rp, cnt;
  logic                        pop, armed, any_ret;
  int                          npush, ndrop, free_sp;
  logic [ROB_IDW:0]            occ_n;
  logic [16:0]                 drop_sum;
  wd_t                         st;
  logic [TS_W-1:0]             wd_cnt;

  // Table update order: results, then retires (reading start-of-cycle
  // state), then alloc overwrites, then nuke wipes every valid bit.
  always_comb begin
    tv_n  = tv;
    tr_n  = tr;
    err_n = err_vec;
    rec   = '0;
    hi_oh = '0;
    for (int i = 0; i < NUM_RES; i++)
      if (res_valid[i] && tv[res_id[i]]) tr_n[res_id[i]] = 1'b1;
    for (int j = 0; j < NUM_RET; j++) begin
      hi_oh[j]     = ret_valid[j] && ((ret_valid >> (j + 1)) == '0);
      rec[j].robid = ret_id[j];
      rec[j].pc    = tpc[ret_id[j]];
      rec[j].lat   = ts - tts[ret_id[j]];
      rec[j].nuke  = ret_nuke & hi_oh[j];
      if (ret_valid[j]) begin
        if (!tv[ret_id[j]])      err_n[1] = 1'b1;
        else if (!tr[ret_id[j]]) err_n[0] = 1'b1;
        tv_n[ret_id[j]] = 1'b0;
      end
    end
    if (alloc_valid) begin
      if (tv_n[alloc_robid]) err_n[2] = 1'b1;
      tv_n[alloc_robid] = 1'b1;
      tr_n[alloc_robid] = 1'b0;
    end
    if (ret_nuke) tv_n = '0;
  end

  always_comb begin
    occ_n = '0;
    for (int e = 0; e < NENT; e++) occ_n = occ_n + (ROB_IDW+1)'(tv_n[e]);
  end

  // Trace FIFO: a same-cycle pop counts as free space; lanes that do not fit
  // are dropped. Nothing is pushed until one edge after reset release.
  assign cnt         = wp - rp;
  assign trace_valid = (wp != rp);
  assign pop         = trace_valid & trace_ready;
  assign trace_data  = trace_valid ? mem[rp[PW-1:0]] : '0;
  assign any_ret     = |ret_valid;

  always_comb begin
    push    = '0;
    slot    = '0;
    npush   = 0;
    ndrop   = 0;
    free_sp = TRACE_DEPTH - int'(cnt) + int'(pop);
    for (int j = 0; j < NUM_RET; j++)
      if (ret_valid[j] && armed) begin
        if (npush < free_sp) begin
          push[j] = 1'b1;
          slot[j] = wp[PW-1:0] + PW'(npush);
          npush++;
        end else begin
          ndrop++;
        end
      end
  end

  assign drop_sum = {1'b0, drop_cnt} + 17'(ndrop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts          <= '0;
      tv          <= '0;
      tr          <= '0;
      err_vec     <= '0;
      wp          <= '0;
      rp          <= '0;
      drop_cnt    <= '0;
      outstanding <= '0;
      armed       <= 1'b0;
    end else begin
      ts          <= ts + TS_W'(1);
      tv          <= tv_n;
      tr          <= tr_n;
      err_vec     <= err_n;
      wp          <= wp + (PW+1)'(npush);
      rp          <= rp + (PW+1)'(pop);
      drop_cnt    <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      outstanding <= occ_n;
      armed       <= 1'b1;
    end
  end

  // Payload storage needs no reset: it is qualified by tv / FIFO pointers.
  always_ff @(posedge clk) begin
    if (alloc_valid) begin
      tpc[alloc_robid] <= alloc_pc;
      tts[alloc_robid] <= ts;
    end
    for (int j = 0; j < NUM_RET; j++)
      if (push[j]) mem[slot[j]] <= rec[j];
  end

  // Watchdog: wd_cnt counts cycles since the last retire while in RUN.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st     <= WD_IDLE;
      wd_cnt <= '0;
      hang   <= 1'b0;
    end else begin
      case (st)
        WD_IDLE: begin
          wd_cnt <= '0;
          if (outstanding != '0 && cfg_timeout != '0) st <= WD_RUN;
        end
        WD_RUN: begin
          if (outstanding == '0 || cfg_timeout == '0) begin
            st     <= WD_IDLE;
            wd_cnt <= '0;
          end else if (any_ret) begin
            wd_cnt <= '0;
          end else if (wd_cnt == cfg_timeout - TS_W'(1)) begin
            st     <= hang_clr ? WD_IDLE : WD_HANG;
            hang   <= !hang_clr;
            wd_cnt <= '0;
          end else begin
            wd_cnt <= wd_cnt + TS_W'(1);
          end
        end
        WD_HANG: begin
          if (hang_clr) begin
            st   <= WD_IDLE;
            hang <= 1'b0;
          end
        end
        default: begin
          st   <= WD_IDLE;
          hang <= 1'b0;
        end
      endcase
    end
  end

`ifdef CORE_TRACE_MON_LATSTAT_EN
  logic [TS_W-1:0]    lm_n;
  logic [ROB_IDW-1:0] lr_n;

  // Strict compare scanned from lane 0 makes the lowest lane win ties.
  always_comb begin
    lm_n = lat_max;
    lr_n = lat_max_robid;
    for (int j = 0; j < NUM_RET; j++)
      if (ret_valid[j] && rec[j].lat > lm_n) begin
        lm_n = rec[j].lat;
        lr_n = rec[j].robid;
      end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lat_max       <= '0;
      lat_max_robid <= '0;
    end else begin
      lat_max       <= lm_n;
      lat_max_robid <= lr_n;
    end
  end
`endif

endmodule

// File: tb/tb_core_trace_mon.sv
module tb_core_trace_mon;
  localparam int IDW = 5, NRES = 2, NRET = 2, DEPTH = 16, TSW = 16;
  localparam int RW  = IDW + 32 + TSW + 1;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 alloc_valid;
  logic [IDW-1:0]       alloc_robid;
  logic [31:0]          alloc_pc;
  logic [NRES-1:0]      res_valid;
  logic [NRES*IDW-1:0]  res_robid;
  logic [NRET-1:0]      ret_valid;
  logic [NRET*IDW-1:0]  ret_robid;
  logic                 ret_nuke;
  logic [TSW-1:0]       cfg_timeout;
  logic                 hang_clr;
  logic                 trace_valid;
  logic                 trace_ready;
  logic [RW-1:0]        trace_data;
  logic                 hang;
  logic [2:0]           err_vec;
  logic [15:0]          drop_cnt;
  logic [IDW:0]         outstanding;

  core_trace_mon #(.ROB_IDW(IDW), .NUM_RES(NRES), .NUM_RET(NRET),
                   .TRACE_DEPTH(DEPTH), .TS_W(TSW)) dut (
    .clk(clk), .reset_n(reset_n),
    .alloc_valid(alloc_valid), .alloc_robid(alloc_robid), .alloc_pc(alloc_pc),
    .res_valid(res_valid), .res_robid(res_robid),
    .ret_valid(ret_valid), .ret_robid(ret_robid), .ret_nuke(ret_nuke),
    .cfg_timeout(cfg_timeout), .hang_clr(hang_clr),
    .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_data(trace_data),
    .hang(hang), .err_vec(err_vec), .drop_cnt(drop_cnt), .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0;
  logic [TSW-1:0] tb_ts;

  // Reference timestamp: zero in reset, +1 per edge.
  always @(posedge clk or negedge reset_n)
    if (!reset_n) tb_ts <= '0;
    else          tb_ts <= tb_ts + 1'b1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] mkrec(input int id, input logic [31:0] pc,
                                          input int lat, input logic nk);
    return {IDW'(id), pc, TSW'(lat), nk};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    alloc_valid = 1'b0;
    res_valid   = '0;
    ret_valid   = '0;
    ret_nuke    = 1'b0;
    hang_clr    = 1'b0;
  endtask

  task automatic do_alloc(input int id, input logic [31:0] pc);
    alloc_valid = 1'b1;
    alloc_robid = IDW'(id);
    alloc_pc    = pc;
    step();
    clr();
  endtask

  task automatic do_res(input int id);
    res_valid = 2'b01;
    res_robid = {IDW'(0), IDW'(id)};
    step();
    clr();
  endtask

  task automatic do_ret(input int n, input int id0, input int id1, input logic nk);
    ret_valid = (n == 2) ? 2'b11 : (n == 1) ? 2'b01 : 2'b00;
    ret_robid = {IDW'(id1), IDW'(id0)};
    ret_nuke  = nk;
    step();
    clr();
  endtask

  task automatic wait_ts(input int t, input int budget);
    int k = 0;
    while (tb_ts != TSW'(t) && k < budget) begin
      step();
      k++;
    end
    if (tb_ts != TSW'(t)) chk("wait_ts", 64'(tb_ts), 64'(t));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL sim_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_q[$];
    int seen, k;
    logic [TSW-1:0] ta0, tr0;

    reset_n = 1'b0;
    clr();
    alloc_robid = '0; alloc_pc = '0; res_robid = '0; ret_robid = '0;
    cfg_timeout = '0; trace_ready = 1'b0;
    step(); step();
    chk("rst_tvalid", 64'(trace_valid), 0);
    chk("rst_tdata",  64'(trace_data),  0);
    chk("rst_hang",   64'(hang),        0);
    chk("rst_err",    64'(err_vec),     0);
    chk("rst_drop",   64'(drop_cnt),    0);
    chk("rst_outst",  64'(outstanding), 0);
    reset_n = 1'b1;

    // Basic record: alloc ts 10, result ts 12, retire ts 15.
    wait_ts(10, 50);
    do_alloc(3, 32'h100);
    chk("alloc_outst", 64'(outstanding), 1);
    wait_ts(12, 10);
    do_res(3);
    wait_ts(15, 10);
    do_ret(1, 3, 0, 1'b0);
    chk("rec_valid", 64'(trace_valid), 1);
    chk("rec_data",  64'(trace_data), 64'(mkrec(3, 32'h100, 5, 1'b0)));
    chk("rec_err",   64'(err_vec), 0);
    chk("rec_outst", 64'(outstanding), 0);
    trace_ready = 1'b1; step(); trace_ready = 1'b0;
    chk("rec_popped", 64'(trace_valid), 0);

    // Error flags.
    do_ret(1, 7, 0, 1'b0);
    chk("err_unalloc", 64'(err_vec), 3'b010);
    do_alloc(9, 32'h900);
    do_ret(1, 9, 0, 1'b0);
    chk("err_nores", 64'(err_vec), 3'b011);
    do_alloc(4, 32'h400);
    do_alloc(4, 32'h440);
    chk("err_dbl",    64'(err_vec), 3'b111);
    chk("dbl_outst",  64'(outstanding), 1);
    chk("err_recs",   64'(trace_valid), 1);

    // Async reset mid-operation discards records; no push on first edge.
    reset_n = 1'b0;
    #1;
    chk("arst_tvalid", 64'(trace_valid), 0);
    chk("arst_err",    64'(err_vec), 0);
    chk("arst_outst",  64'(outstanding), 0);
    step();
    reset_n = 1'b1;
    do_ret(1, 7, 0, 1'b0);
    chk("first_edge_nopush", 64'(trace_valid), 0);

    // FIFO fill to 15, then two lanes with one slot left.
    for (int c = 0; c < 7; c++) do_ret(2, 2*c, 2*c+1, 1'b0);
    do_ret(1, 14, 0, 1'b0);
    chk("fill_drop0", 64'(drop_cnt), 0);
    chk("fill_head",  64'(trace_data[RW-1 -: IDW]), 0);
    do_ret(2, 20, 21, 1'b0);
    chk("full_drop1", 64'(drop_cnt), 1);
    step();
    chk("hold_head",  64'(trace_data[RW-1 -: IDW]), 0);
    trace_ready = 1'b1;
    do_ret(2, 22, 23, 1'b0);
    trace_ready = 1'b0;
    chk("pop_free_drop2", 64'(drop_cnt), 2);
    for (int i = 1; i <= 14; i++) exp_q.push_back(i);
    exp_q.push_back(20);
    exp_q.push_back(22);
    trace_ready = 1'b1;
    foreach (exp_q[i]) begin
      chk($sformatf("drain%0d", i), 64'(trace_data[RW-1 -: IDW]), 64'(exp_q[i]));
      step();
    end
    trace_ready = 1'b0;
    chk("drain_empty", 64'(trace_valid), 0);

    // Nuke with 8 outstanding, lane 1 carries the nuke, alloc same cycle.
    do_reset();
    ta0 = tb_ts;
    for (int i = 0; i < 8; i++) do_alloc(i, 32'h1000 + 32'(i*4));
    for (int i = 0; i < 8; i++) do_res(i);
    chk("nk_outst8", 64'(outstanding), 8);
    tr0 = tb_ts;
    alloc_valid = 1'b1; alloc_robid = IDW'(10); alloc_pc = 32'hA00;
    ret_valid = 2'b11; ret_robid = {IDW'(1), IDW'(0)}; ret_nuke = 1'b1;
    step(); clr();
    chk("nk_outst0", 64'(outstanding), 0);
    chk("nk_err",    64'(err_vec), 0);
    chk("nk_rec0",   64'(trace_data), 64'(mkrec(0, 32'h1000, int'(TSW'(tr0 - ta0)), 1'b0)));
    trace_ready = 1'b1; step(); trace_ready = 1'b0;
    chk("nk_rec1",   64'(trace_data), 64'(mkrec(1, 32'h1004, int'(TSW'(tr0 - ta0 - 1'b1)), 1'b1)));
    do_ret(1, 10, 0, 1'b0);
    chk("nk_alloc_cleared", 64'(err_vec), 3'b010);

    // Watchdog.
    do_reset();
    trace_ready = 1'b1;
    cfg_timeout = 16'd40;
    do_alloc(5, 32'h500);
    do_alloc(6, 32'h600);
    do_res(6);
    step(); step();
    do_ret(1, 6, 0, 1'b0);
    for (int i = 1; i <= 39; i++) step();
    chk("wd_39", 64'(hang), 0);
    step();
    chk("wd_40", 64'(hang), 1);
    hang_clr = 1'b1; step(); hang_clr = 1'b0;
    chk("wd_clr", 64'(hang), 0);
    seen = 0;
    hang_clr = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (hang) seen = 1;
    end
    hang_clr = 1'b0;
    chk("wd_clr_at_fire", 64'(seen), 0);
    cfg_timeout = '0;

    // Drop saturation while running the timestamp up to the wrap.
    do_reset();
    trace_ready = 1'b0;
    ret_valid = 2'b11; ret_robid = {IDW'(1), IDW'(0)};
    k = 0;
    while (tb_ts < 16'hFFE0 && k < 70000) begin
      step();
      k++;
    end
    clr();
    chk("drop_sat", 64'(drop_cnt), 16'hFFFF);
    trace_ready = 1'b1;
    k = 0;
    while (trace_valid && k < 40) begin
      step();
      k++;
    end
    chk("sat_drain", 64'(trace_valid), 0);
    wait_ts(16'hFFFE, 100);
    do_alloc(3, 32'hABCD);
    do_res(3);
    wait_ts(3, 10);
    do_ret(1, 3, 0, 1'b0);
    chk("wrap_rec", 64'(trace_data), 64'(mkrec(3, 32'hABCD, 5, 1'b0)));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
